// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use stall detection and a saturating stall counter.
// One cycle ID->EX; forwarding and Stall are combinational. Upstream holds ID while Stall=1; this stage inserts a bubble.
module id_ex_stage #(
  parameter logic [15:0] STALL_MAX = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_Valid,
  input  logic [4:0]  ID_ALUCode,
  input  logic [4:0]  ID_RsAddr,
  input  logic [4:0]  ID_RtAddr,
  input  logic [31:0] ID_RsData,
  input  logic [31:0] ID_RtData,
  input  logic [31:0] ID_Imm,
  input  logic [4:0]  ID_Shamt,
  input  logic        ID_ALUSrcA,
  input  logic        ID_ALUSrcB,
  input  logic        ID_RegWrite,
  input  logic        ID_MemRead,
  input  logic [4:0]  ID_RegWriteAddr,
  input  logic        MEM_RegWrite,
  input  logic [4:0]  MEM_RegWriteAddr,
  input  logic [31:0] MEM_ALUResult,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_RegWriteAddr,
  input  logic [31:0] WB_RegWriteData,
  input  logic        Flush,
  output logic        EX_Valid,
  output logic [4:0]  EX_ALUCode,
  output logic [31:0] EX_A,
  output logic [31:0] EX_B,
  output logic [31:0] EX_StoreData,
  output logic        EX_RegWrite,
  output logic        EX_MemRead,
  output logic [4:0]  EX_RegWriteAddr,
  output logic        Stall,
  output logic [15:0] StallCount
);

  logic        r_valid;
  logic [4:0]  r_alucode;
  logic [4:0]  r_rs_addr;
  logic [4:0]  r_rt_addr;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_imm;
  logic [4:0]  r_shamt;
  logic        r_srca;
  logic        r_srcb;
  logic        r_regwrite;
  logic        r_memread;
  logic [4:0]  r_wa;
  logic [15:0] r_stall_cnt;

  logic        w_stall;
  logic        w_rs_hit;
  logic        w_rt_hit;
  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;

  // Rt only matters to the consumer when it is a real ALU operand or the store data of a non-load.
  assign w_rs_hit = (r_wa == ID_RsAddr);
  assign w_rt_hit = (r_wa == ID_RtAddr) && (!ID_ALUSrcB || !ID_MemRead);
  assign w_stall  = r_valid && r_memread && (r_wa != 5'd0) && ID_Valid &&
                    (w_rs_hit || w_rt_hit) && !Flush;

  always_comb begin
    w_fwd_rs = r_rs_data;
    if (MEM_RegWrite && (MEM_RegWriteAddr != 5'd0) && (MEM_RegWriteAddr == r_rs_addr))
      w_fwd_rs = MEM_ALUResult;
    else if (WB_RegWrite && (WB_RegWriteAddr != 5'd0) && (WB_RegWriteAddr == r_rs_addr))
      w_fwd_rs = WB_RegWriteData;
  end

  always_comb begin
    w_fwd_rt = r_rt_data;
    if (MEM_RegWrite && (MEM_RegWriteAddr != 5'd0) && (MEM_RegWriteAddr == r_rt_addr))
      w_fwd_rt = MEM_ALUResult;
    else if (WB_RegWrite && (WB_RegWriteAddr != 5'd0) && (WB_RegWriteAddr == r_rt_addr))
      w_fwd_rt = WB_RegWriteData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_alucode   <= 5'd0;
      r_rs_addr   <= 5'd0;
      r_rt_addr   <= 5'd0;
      r_rs_data   <= 32'd0;
      r_rt_data   <= 32'd0;
      r_imm       <= 32'd0;
      r_shamt     <= 5'd0;
      r_srca      <= 1'b0;
      r_srcb      <= 1'b0;
      r_regwrite  <= 1'b0;
      r_memread   <= 1'b0;
      r_wa        <= 5'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_rs_addr <= ID_RsAddr;
      r_rt_addr <= ID_RtAddr;
      r_rs_data <= ID_RsData;
      r_rt_data <= ID_RtData;
      r_imm     <= ID_Imm;
      r_shamt   <= ID_Shamt;
      r_srca    <= ID_ALUSrcA;
      r_srcb    <= ID_ALUSrcB;
      r_wa      <= ID_RegWriteAddr;
      // Bubble: only the control fields need to be killed, operands are don't-care.
      if (Flush || w_stall) begin
        r_valid    <= 1'b0;
        r_alucode  <= 5'd0;
        r_regwrite <= 1'b0;
        r_memread  <= 1'b0;
      end else begin
        r_valid    <= ID_Valid;
        r_alucode  <= ID_ALUCode;
        r_regwrite <= ID_Valid && ID_RegWrite;
        r_memread  <= ID_Valid && ID_MemRead;
      end
      if (w_stall && (r_stall_cnt != STALL_MAX))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign EX_Valid        = r_valid;
  assign EX_ALUCode      = r_alucode;
  assign EX_A            = r_srca ? {27'd0, r_shamt} : w_fwd_rs;
  assign EX_B            = r_srcb ? r_imm : w_fwd_rt;
  assign EX_StoreData    = w_fwd_rt;
  assign EX_RegWrite     = r_regwrite;
  assign EX_MemRead      = r_memread;
  assign EX_RegWriteAddr = r_wa;
  assign Stall           = w_stall;
  assign StallCount      = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: driver pushes hand-computed expectations, a negedge monitor pops and compares.
// A second instance with a small saturation limit shares the stimulus so the counter ceiling is reached quickly.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_Valid, ID_ALUSrcA, ID_ALUSrcB, ID_RegWrite, ID_MemRead;
  logic [4:0]  ID_ALUCode, ID_RsAddr, ID_RtAddr, ID_Shamt, ID_RegWriteAddr;
  logic [31:0] ID_RsData, ID_RtData, ID_Imm;
  logic        MEM_RegWrite, WB_RegWrite, Flush;
  logic [4:0]  MEM_RegWriteAddr, WB_RegWriteAddr;
  logic [31:0] MEM_ALUResult, WB_RegWriteData;

  logic        EX_Valid, EX_RegWrite, EX_MemRead, Stall;
  logic [4:0]  EX_ALUCode, EX_RegWriteAddr;
  logic [31:0] EX_A, EX_B, EX_StoreData;
  logic [15:0] StallCount;

  logic        s_Valid, s_RegWrite, s_MemRead, s_Stall;
  logic [4:0]  s_ALUCode, s_RegWriteAddr;
  logic [31:0] s_A, s_B, s_StoreData;
  logic [15:0] s_StallCount;

  localparam logic [15:0] SAT_MAX = 16'd5;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .ID_Valid(ID_Valid), .ID_ALUCode(ID_ALUCode), .ID_RsAddr(ID_RsAddr), .ID_RtAddr(ID_RtAddr),
    .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_Imm(ID_Imm), .ID_Shamt(ID_Shamt),
    .ID_ALUSrcA(ID_ALUSrcA), .ID_ALUSrcB(ID_ALUSrcB), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_RegWriteAddr(ID_RegWriteAddr),
    .MEM_RegWrite(MEM_RegWrite), .MEM_RegWriteAddr(MEM_RegWriteAddr), .MEM_ALUResult(MEM_ALUResult),
    .WB_RegWrite(WB_RegWrite), .WB_RegWriteAddr(WB_RegWriteAddr), .WB_RegWriteData(WB_RegWriteData),
    .Flush(Flush),
    .EX_Valid(EX_Valid), .EX_ALUCode(EX_ALUCode), .EX_A(EX_A), .EX_B(EX_B),
    .EX_StoreData(EX_StoreData), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_RegWriteAddr(EX_RegWriteAddr), .Stall(Stall), .StallCount(StallCount)
  );

  id_ex_stage #(.STALL_MAX(SAT_MAX)) dut_sat (
    .clk(clk), .reset(reset),
    .ID_Valid(ID_Valid), .ID_ALUCode(ID_ALUCode), .ID_RsAddr(ID_RsAddr), .ID_RtAddr(ID_RtAddr),
    .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_Imm(ID_Imm), .ID_Shamt(ID_Shamt),
    .ID_ALUSrcA(ID_ALUSrcA), .ID_ALUSrcB(ID_ALUSrcB), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_RegWriteAddr(ID_RegWriteAddr),
    .MEM_RegWrite(MEM_RegWrite), .MEM_RegWriteAddr(MEM_RegWriteAddr), .MEM_ALUResult(MEM_ALUResult),
    .WB_RegWrite(WB_RegWrite), .WB_RegWriteAddr(WB_RegWriteAddr), .WB_RegWriteData(WB_RegWriteData),
    .Flush(Flush),
    .EX_Valid(s_Valid), .EX_ALUCode(s_ALUCode), .EX_A(s_A), .EX_B(s_B),
    .EX_StoreData(s_StoreData), .EX_RegWrite(s_RegWrite), .EX_MemRead(s_MemRead),
    .EX_RegWriteAddr(s_RegWriteAddr), .Stall(s_Stall), .StallCount(s_StallCount)
  );

  // mask bits: 0 valid, 1 A, 2 B, 3 store, 4 regwrite, 5 memread, 6 alucode, 7 wa, 8 stall, 9 count, 10 sat count
  typedef struct {
    string       nm;
    logic [10:0] m;
    logic        v, rw, mr, st;
    logic [31:0] a, b, sd;
    logic [4:0]  alu, wa;
    logic [15:0] cnt, cs;
  } exp_t;

  localparam logic [10:0] M_ALL = 11'h7FF;
  localparam logic [10:0] M_CNT = 11'h700;
  localparam logic [10:0] M_BUB = 11'h771;
  localparam logic [10:0] M_HZ  = 11'h7A1;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[0])  cmp(e.nm, "EX_Valid", {31'd0, EX_Valid}, {31'd0, e.v});
      if (e.m[1])  cmp(e.nm, "EX_A", EX_A, e.a);
      if (e.m[2])  cmp(e.nm, "EX_B", EX_B, e.b);
      if (e.m[3])  cmp(e.nm, "EX_StoreData", EX_StoreData, e.sd);
      if (e.m[4])  cmp(e.nm, "EX_RegWrite", {31'd0, EX_RegWrite}, {31'd0, e.rw});
      if (e.m[5])  cmp(e.nm, "EX_MemRead", {31'd0, EX_MemRead}, {31'd0, e.mr});
      if (e.m[6])  cmp(e.nm, "EX_ALUCode", {27'd0, EX_ALUCode}, {27'd0, e.alu});
      if (e.m[7])  cmp(e.nm, "EX_RegWriteAddr", {27'd0, EX_RegWriteAddr}, {27'd0, e.wa});
      if (e.m[8])  cmp(e.nm, "Stall", {31'd0, Stall}, {31'd0, e.st});
      if (e.m[9])  cmp(e.nm, "StallCount", {16'd0, StallCount}, {16'd0, e.cnt});
      if (e.m[10]) cmp(e.nm, "StallCount_sat", {16'd0, s_StallCount}, {16'd0, e.cs});
    end
  end

  task automatic exp_push(input string nm, input logic [10:0] m, input logic v,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                          input logic rw, input logic mr, input logic [4:0] alu, input logic [4:0] wa,
                          input logic st, input logic [15:0] cnt, input logic [15:0] cs);
    exp_t e;
    e.nm = nm; e.m = m; e.v = v; e.a = a; e.b = b; e.sd = sd; e.rw = rw; e.mr = mr;
    e.alu = alu; e.wa = wa; e.st = st; e.cnt = cnt; e.cs = cs;
    q.push_back(e);
  endtask

  task automatic id_set(input logic v, input logic [4:0] alu, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                        input logic [4:0] sh, input logic sa, input logic sb, input logic rw,
                        input logic mr, input logic [4:0] wa);
    ID_Valid = v; ID_ALUCode = alu; ID_RsAddr = rs; ID_RtAddr = rt; ID_RsData = rsd; ID_RtData = rtd;
    ID_Imm = imm; ID_Shamt = sh; ID_ALUSrcA = sa; ID_ALUSrcB = sb; ID_RegWrite = rw; ID_MemRead = mr;
    ID_RegWriteAddr = wa;
  endtask

  task automatic fwd_set(input logic mrw, input logic [4:0] mwa, input logic [31:0] mres,
                         input logic wrw, input logic [4:0] wwa, input logic [31:0] wdat);
    MEM_RegWrite = mrw; MEM_RegWriteAddr = mwa; MEM_ALUResult = mres;
    WB_RegWrite = wrw; WB_RegWriteAddr = wwa; WB_RegWriteData = wdat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lw r4, 8(r1) and a consumer of r4 through Rs
  task automatic id_lw4();
    id_set(1, 5'd0, 5'd1, 5'd4, 32'h100, 32'h0, 32'h8, 5'd0, 0, 1, 1, 1, 5'd4);
  endtask
  task automatic id_use4();
    id_set(1, 5'd0, 5'd4, 5'd2, 32'h0, 32'h7, 32'h0, 5'd0, 0, 0, 1, 0, 5'd11);
  endtask

  initial begin
    reset = 1'b1;
    Flush = 1'b0;
    id_set(0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 5'd0);
    fwd_set(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    tick(); tick();

    reset = 1'b0;
    id_set(1, 5'd0, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 5'd0, 0, 0, 1, 0, 5'd8);
    exp_push("reset", M_ALL, 0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 5'd0, 0, 16'd0, 16'd0);
    tick();

    id_set(1, 5'd2, 5'd3, 5'd5, 32'h11, 32'h22, 32'h0, 5'd0, 0, 0, 1, 0, 5'd9);
    exp_push("add", M_ALL, 1, 32'd5, 32'd7, 32'd7, 1, 0, 5'd0, 5'd8, 0, 16'd0, 16'd0);
    tick();

    id_set(0, 5'd2, 5'd3, 5'd5, 32'h11, 32'h22, 32'h0, 5'd0, 0, 0, 1, 0, 5'd9);
    fwd_set(1, 5'd3, 32'hAAAA, 1, 5'd3, 32'hBBBB);
    exp_push("fwd_mem", M_ALL, 1, 32'hAAAA, 32'h22, 32'h22, 1, 0, 5'd2, 5'd9, 0, 16'd0, 16'd0);
    tick();

    id_set(1, 5'd3, 5'd0, 5'd0, 32'h55, 32'h66, 32'h0, 5'd0, 0, 0, 1, 0, 5'd10);
    fwd_set(1, 5'd5, 32'hCCCC, 1, 5'd3, 32'hBBBB);
    exp_push("fwd_wb", 11'h73F, 0, 32'hBBBB, 32'hCCCC, 32'hCCCC, 0, 0, 5'd0, 5'd0, 0, 16'd0, 16'd0);
    tick();

    id_lw4();
    fwd_set(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
    exp_push("r0_nofwd", M_ALL, 1, 32'h55, 32'h66, 32'h66, 1, 0, 5'd3, 5'd10, 0, 16'd0, 16'd0);
    tick();

    id_use4();
    fwd_set(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    exp_push("load_use", M_ALL, 1, 32'h100, 32'h8, 32'h0, 1, 1, 5'd0, 5'd4, 1, 16'd0, 16'd0);
    tick();

    exp_push("stall_bubble", M_BUB, 0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 5'd0, 0, 16'd1, 16'd1);
    tick();

    id_lw4();
    fwd_set(1, 5'd4, 32'h1234, 0, 5'd0, 32'h0);
    exp_push("fwd_load", M_ALL, 1, 32'h1234, 32'h7, 32'h7, 1, 0, 5'd0, 5'd11, 0, 16'd1, 16'd1);
    tick();

    id_use4();
    fwd_set(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    Flush = 1'b1;
    exp_push("flush_hazard", 11'h7A7, 1, 32'h100, 32'h8, 32'h0, 0, 1, 5'd0, 5'd4, 0, 16'd1, 16'd1);
    tick();

    Flush = 1'b0;
    id_set(1, 5'd4, 5'd0, 5'd7, 32'h0, 32'h80000000, 32'h0, 5'd31, 1, 0, 1, 0, 5'd12);
    exp_push("flush_bubble", M_BUB, 0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 5'd0, 0, 16'd1, 16'd1);
    tick();

    id_set(1, 5'd0, 5'd1, 5'd0, 32'h100, 32'h0, 32'h4, 5'd0, 0, 1, 1, 1, 5'd6);
    exp_push("shift", M_ALL, 1, 32'd31, 32'h80000000, 32'h80000000, 1, 0, 5'd4, 5'd12, 0, 16'd1, 16'd1);
    tick();

    // load whose Rt is only its destination must not stall
    id_set(1, 5'd0, 5'd1, 5'd6, 32'h100, 32'h0, 32'h4, 5'd0, 0, 1, 1, 1, 5'd6);
    exp_push("rt_load_nostall", M_HZ, 1, 32'h0, 32'h0, 32'h0, 0, 1, 5'd0, 5'd6, 0, 16'd1, 16'd1);
    tick();

    // store reading r6 as data does stall
    id_set(1, 5'd0, 5'd1, 5'd6, 32'h100, 32'h99, 32'h4, 5'd0, 0, 1, 0, 0, 5'd0);
    exp_push("rt_store_stall", M_HZ, 1, 32'h0, 32'h0, 32'h0, 0, 1, 5'd0, 5'd6, 1, 16'd1, 16'd1);
    tick();

    id_lw4();
    exp_push("rt_bubble", M_BUB, 0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 5'd0, 0, 16'd2, 16'd2);
    tick();

    id_use4();
    reset = 1'b1;
    exp_push("hazard_at_reset", M_HZ, 1, 32'h0, 32'h0, 32'h0, 0, 1, 5'd0, 5'd4, 1, 16'd2, 16'd2);
    tick();

    reset = 1'b0;
    id_set(0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 5'd0);
    exp_push("reset_mid_hazard", M_ALL, 0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 5'd0, 0, 16'd0, 16'd0);
    tick();

    for (int i = 0; i < 8; i++) begin
      logic [15:0] n, ns;
      n  = 16'(i);
      ns = (n > SAT_MAX) ? SAT_MAX : n;
      id_lw4();
      exp_push("sat_load", M_CNT, 0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 5'd0, 0, n, ns);
      tick();
      id_use4();
      exp_push("sat_use", M_CNT, 0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 5'd0, 1, n, ns);
      tick();
    end

    id_set(0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 5'd0);
    exp_push("sat_hold", M_CNT, 0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 5'd0, 0, 16'd8, SAT_MAX);
    reset = 1'b1;
    tick();

    reset = 1'b0;
    exp_push("sat_reset", M_ALL, 0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 5'd0, 0, 16'd0, 16'd0);
    tick();

    for (int k = 0; k < 10 && q.size() > 0; k++) tick();
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
